vga_timing_gen: RTL and testbench

Parametrised VGA raster timing generator. It produces horizontal and vertical sync with configurable porches, widths and polarity, plus an active-video flag, pixel/line coordinates and frame/line start strobes. All outputs are registered and mutually aligned. It sits between the pixel clock domain and the game renderer/colour mux, and supersedes the fixed active-region-only sync counter.

---
 rtl/vga_timing_pkg.sv | 28 ++
 rtl/vga_timing_gen_if.sv | 34 +++
 rtl/vga_axis_counter.sv | 64 ++++++
 rtl/vga_timing_gen.sv | 63 ++++++
 tb/tb_vga_timing_gen.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/vga_timing_pkg.sv
// Purpose: shared constants and helpers for the VGA raster timing generator.
// Holds the default 640x480@60 segment lengths, the counter width and a
// helper that sums the four segments of an axis into its total length.
package vga_timing_pkg;

  // Default horizontal segments, in pixels
  localparam int unsigned H_ACTIVE = 640;
  localparam int unsigned H_FP     = 16;
  localparam int unsigned H_SYNC   = 96;
  localparam int unsigned H_BP     = 48;

  // Default vertical segments, in lines
  localparam int unsigned V_ACTIVE = 480;
  localparam int unsigned V_FP     = 10;
  localparam int unsigned V_SYNC   = 2;
  localparam int unsigned V_BP     = 33;

  localparam int unsigned CNT_W    = 10;

  // Total length of one axis from its four segments
  function automatic int unsigned vga_total(input int unsigned active,
                                            input int unsigned fp,
                                            input int unsigned sync,
                                            input int unsigned bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Purpose: raster timing bundle between the generator and its consumers.
//   i_En           pixel advance enable (driven by the consumer side)
//   o_HSync/VSync  syncs at their configured polarity
//   o_Active       visible-region flag
//   o_Col_Count    current column
//   o_Row_Count    current row
//   o_Line_Start   one-clock strobe on entry to col 0
//   o_Frame_Start  one-clock strobe on entry to (0,0)
interface vga_timing_gen_if #(
  parameter int unsigned CNT_W = vga_timing_pkg::CNT_W
);
  logic             i_En;
  logic             o_HSync;
  logic             o_VSync;
  logic             o_Active;
  logic [CNT_W-1:0] o_Col_Count;
  logic [CNT_W-1:0] o_Row_Count;
  logic             o_Line_Start;
  logic             o_Frame_Start;

  // Generator side
  modport master (
    input  i_En,
    output o_HSync, o_VSync, o_Active, o_Col_Count, o_Row_Count,
           o_Line_Start, o_Frame_Start
  );

  // Renderer / colour-mux side
  modport slave (
    output i_En,
    input  o_HSync, o_VSync, o_Active, o_Col_Count, o_Row_Count,
           o_Line_Start, o_Frame_Start
  );
endinterface

// File: rtl/vga_axis_counter.sv
// Purpose: one raster axis (horizontal or vertical) counter with region decode.
//   i_Clk, i_Rst  clock, asynchronous active-high reset
//   advance       step the count by one (wrapping at the axis total)
//   count         current position, resets to TOTAL-1
//   wrap_c        combinational: this edge takes count from TOTAL-1 to 0
//   sync          registered sync, POL while in the sync segment
//   in_active     registered, count < ACTIVE
//   start         registered one-clock strobe on entry to position 0
module vga_axis_counter
  import vga_timing_pkg::vga_total;
#(
  parameter int unsigned ACTIVE = 640,
  parameter int unsigned FP     = 16,
  parameter int unsigned SYNC   = 96,
  parameter int unsigned BP     = 48,
  parameter bit          POL    = 1'b0,
  parameter int unsigned CNT_W  = 10
) (
  input  logic             i_Clk,
  input  logic             i_Rst,
  input  logic             advance,
  output logic [CNT_W-1:0] count,
  output logic             wrap_c,
  output logic             sync,
  output logic             in_active,
  output logic             start
);

  localparam int unsigned      TOTAL    = vga_total(ACTIVE, FP, SYNC, BP);
  localparam int unsigned      SYNC_BEG = ACTIVE + FP;
  localparam int unsigned      SYNC_END = ACTIVE + FP + SYNC;
  localparam logic [CNT_W-1:0] LAST     = CNT_W'(TOTAL - 1);

  logic [CNT_W-1:0] count_nxt;
  logic             at_last;

  assign at_last = (count == LAST);
  assign wrap_c  = advance & at_last;

  // Next position; holds when not advancing
  always_comb begin
    count_nxt = count;
    if (advance) begin
      count_nxt = at_last ? '0 : count + CNT_W'(1);
    end
  end

  // Decode from the next count so flags line up with the count they describe
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      count     <= LAST;
      sync      <= ~POL;
      in_active <= 1'b0;
      start     <= 1'b0;
    end else begin
      count     <= count_nxt;
      sync      <= (count_nxt >= CNT_W'(SYNC_BEG) && count_nxt < CNT_W'(SYNC_END))
                   ? POL : ~POL;
      in_active <= (count_nxt < CNT_W'(ACTIVE));
      start     <= wrap_c;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Purpose: VGA raster timing generator built from two chained axis counters.
//   i_Clk  pixel clock
//   i_Rst  asynchronous reset, active-high
//   vif    timing bundle (master side): i_En in; syncs, active flag,
//          col/row counts and line/frame start strobes out
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE = vga_timing_pkg::H_ACTIVE,
  parameter int unsigned H_FP     = vga_timing_pkg::H_FP,
  parameter int unsigned H_SYNC   = vga_timing_pkg::H_SYNC,
  parameter int unsigned H_BP     = vga_timing_pkg::H_BP,
  parameter int unsigned V_ACTIVE = vga_timing_pkg::V_ACTIVE,
  parameter int unsigned V_FP     = vga_timing_pkg::V_FP,
  parameter int unsigned V_SYNC   = vga_timing_pkg::V_SYNC,
  parameter int unsigned V_BP     = vga_timing_pkg::V_BP,
  parameter bit          HS_POL   = 1'b0,
  parameter bit          VS_POL   = 1'b0,
  parameter int unsigned CNT_W    = vga_timing_pkg::CNT_W
) (
  input  logic              i_Clk,
  input  logic              i_Rst,
  vga_timing_gen_if.master  vif
);

  logic h_wrap_c;
  logic v_wrap_unused_c;
  logic h_active;
  logic v_active;

  // Column counter: advances on every enabled pixel clock
  vga_axis_counter #(
    .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP),
    .POL(HS_POL), .CNT_W(CNT_W)
  ) u_h_cnt (
    .i_Clk    (i_Clk),
    .i_Rst    (i_Rst),
    .advance  (vif.i_En),
    .count    (vif.o_Col_Count),
    .wrap_c   (h_wrap_c),
    .sync     (vif.o_HSync),
    .in_active(h_active),
    .start    (vif.o_Line_Start)
  );

  // Row counter: advances only on the column wrap, so its start strobe
  // can only fire together with col 0 and marks the frame start
  vga_axis_counter #(
    .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP),
    .POL(VS_POL), .CNT_W(CNT_W)
  ) u_v_cnt (
    .i_Clk    (i_Clk),
    .i_Rst    (i_Rst),
    .advance  (h_wrap_c),
    .count    (vif.o_Row_Count),
    .wrap_c   (v_wrap_unused_c),
    .sync     (vif.o_VSync),
    .in_active(v_active),
    .start    (vif.o_Frame_Start)
  );

  // Both flags are registered, so the product is aligned with the counts
  assign vif.o_Active = h_active & v_active;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Purpose: scoreboard bench for vga_timing_gen. Three instances (default
// 640x480, a tiny positive-polarity raster and a small negative-polarity
// raster) share clock, reset and a randomised enable; a frame-position model
// predicts every cycle and a monitor compares against it.
module tb_vga_timing_gen;

  typedef struct {
    int unsigned ha, hfp, hs, hbp, va, vfp, vs, vbp;
    bit          hpol, vpol;
  } cfg_t;

  typedef struct packed {
    logic        hs, vs, act, ls, fs;
    logic [31:0] col, row;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic en;
  always #5 clk = ~clk;

  vga_timing_gen_if #(.CNT_W(10)) vif0 (), vif1 (), vif2 ();
  assign vif0.i_En = en;
  assign vif1.i_En = en;
  assign vif2.i_En = en;

  vga_timing_gen #(.CNT_W(10)) u_dut0 (.i_Clk(clk), .i_Rst(rst), .vif(vif0));

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b1), .CNT_W(10)
  ) u_dut1 (.i_Clk(clk), .i_Rst(rst), .vif(vif1));

  vga_timing_gen #(
    .H_ACTIVE(16), .H_FP(4), .H_SYNC(6), .H_BP(4),
    .V_ACTIVE(10), .V_FP(2), .V_SYNC(2), .V_BP(3),
    .HS_POL(1'b0), .VS_POL(1'b0), .CNT_W(10)
  ) u_dut2 (.i_Clk(clk), .i_Rst(rst), .vif(vif2));

  cfg_t        cfg [3];
  int unsigned pos [3];
  exp_t        sb  [3][$];
  int          errors = 0;
  int          checks = 0;

  // Measurement state for the free-running phase
  bit          meas = 1'b0;
  int          cyc = 0;
  int          h_low0, act0, ls_bad0, ls_cnt0;
  int          last_fs [3];
  int          vs_cnt  [3];

  function automatic int unsigned htot(int k);
    return cfg[k].ha + cfg[k].hfp + cfg[k].hs + cfg[k].hbp;
  endfunction

  function automatic int unsigned frame(int k);
    return htot(k) * (cfg[k].va + cfg[k].vfp + cfg[k].vs + cfg[k].vbp);
  endfunction

  // Expected outputs for the current model position of instance k
  function automatic exp_t model(int k, bit in_rst, bit stepped);
    exp_t        e;
    cfg_t        c;
    int unsigned col, row;
    c   = cfg[k];
    col = pos[k] % htot(k);
    row = pos[k] / htot(k);
    e.col = col;
    e.row = row;
    e.hs  = (!in_rst && col >= c.ha + c.hfp && col < c.ha + c.hfp + c.hs) ? c.hpol : ~c.hpol;
    e.vs  = (!in_rst && row >= c.va + c.vfp && row < c.va + c.vfp + c.vs) ? c.vpol : ~c.vpol;
    e.act = !in_rst && col < c.ha && row < c.va;
    e.ls  = stepped && col == 0;
    e.fs  = stepped && pos[k] == 0;
    return e;
  endfunction

  function automatic exp_t actual(int k);
    exp_t a;
    case (k)
      0: a = {vif0.o_HSync, vif0.o_VSync, vif0.o_Active, vif0.o_Line_Start,
              vif0.o_Frame_Start, 32'(vif0.o_Col_Count), 32'(vif0.o_Row_Count)};
      1: a = {vif1.o_HSync, vif1.o_VSync, vif1.o_Active, vif1.o_Line_Start,
              vif1.o_Frame_Start, 32'(vif1.o_Col_Count), 32'(vif1.o_Row_Count)};
      default:
         a = {vif2.o_HSync, vif2.o_VSync, vif2.o_Active, vif2.o_Line_Start,
              vif2.o_Frame_Start, 32'(vif2.o_Col_Count), 32'(vif2.o_Row_Count)};
    endcase
    return a;
  endfunction

  task automatic check(input string name, input exp_t a, input exp_t e);
    checks++;
    if (a != e) begin
      errors++;
      $display("FAIL %s @%0t: got col=%0d row=%0d hs=%b vs=%b act=%b ls=%b fs=%b, expected col=%0d row=%0d hs=%b vs=%b act=%b ls=%b fs=%b",
               name, $time, a.col, a.row, a.hs, a.vs, a.act, a.ls, a.fs,
               e.col, e.row, e.hs, e.vs, e.act, e.ls, e.fs);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, got, exp);
    end
  endtask

  // Sample the outputs of the previous edge for aggregate timing checks
  task automatic measure();
    cyc++;
    if (!meas) return;
    if (vif0.o_Row_Count == 0 && vif0.o_HSync == 1'b0) h_low0++;
    if (vif0.o_Row_Count == 0 && vif0.o_Active) act0++;
    if (vif0.o_Line_Start) begin
      ls_cnt0++;
      if (vif0.o_Col_Count != 0) ls_bad0++;
    end
    if (vif1.o_Frame_Start) begin
      if (last_fs[1] >= 0) begin
        check_int("dut1_frame_period", cyc - last_fs[1], 120);
        check_int("dut1_vsync_clocks", vs_cnt[1], 30);
      end
      last_fs[1] = cyc;
      vs_cnt[1]  = 0;
    end
    if (vif1.o_VSync == 1'b1) vs_cnt[1]++;
    if (vif2.o_Frame_Start) begin
      if (last_fs[2] >= 0) begin
        check_int("dut2_frame_period", cyc - last_fs[2], 510);
        check_int("dut2_vsync_clocks", vs_cnt[2], 60);
      end
      last_fs[2] = cyc;
      vs_cnt[2]  = 0;
    end
    if (vif2.o_VSync == 1'b0) vs_cnt[2]++;
  endtask

  // One clock of stimulus: applied at negedge, expectation queued for the next edge
  task automatic step(input bit r, input bit e);
    bit rst_prev;
    @(negedge clk);
    measure();
    rst_prev = rst;
    rst = r;
    en  = e;
    if (r) begin
      for (int k = 0; k < 3; k++) pos[k] = frame(k) - 1;
      if (!rst_prev) begin
        #1;
        for (int k = 0; k < 3; k++) check($sformatf("dut%0d_async_reset", k), actual(k), model(k, 1'b1, 1'b0));
      end
      for (int k = 0; k < 3; k++) sb[k].push_back(model(k, 1'b1, 1'b0));
    end else begin
      for (int k = 0; k < 3; k++) begin
        if (e) pos[k] = (pos[k] + 1) % frame(k);
        sb[k].push_back(model(k, 1'b0, e));
      end
    end
  endtask

  // Monitor: compare every instance just after each active edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      for (int k = 0; k < 3; k++) begin
        if (sb[k].size() != 0) begin
          e = sb[k].pop_front();
          check($sformatf("dut%0d_cycle", k), actual(k), e);
        end
      end
    end
  end

  initial begin
    int guard;
    cfg[0] = '{640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0};
    cfg[1] = '{8, 2, 3, 2, 4, 1, 2, 1, 1'b1, 1'b1};
    cfg[2] = '{16, 4, 6, 4, 10, 2, 2, 3, 1'b0, 1'b0};
    for (int k = 0; k < 3; k++) begin
      pos[k]     = frame(k) - 1;
      last_fs[k] = -1;
      vs_cnt[k]  = 0;
    end
    h_low0 = 0; act0 = 0; ls_bad0 = 0; ls_cnt0 = 0;
    rst = 1'b1;
    en  = 1'b0;

    // Reset held, then release with enable high for a free run
    repeat (3) step(1'b1, 1'b0);
    meas = 1'b1;
    repeat (1001) step(1'b0, 1'b1);
    meas = 1'b0;
    check_int("dut0_hsync_low_row0", h_low0, 96);
    check_int("dut0_active_row0", act0, 640);
    check_int("dut0_line_start_off_col0", ls_bad0, 0);
    check_int("dut0_line_start_count", ls_cnt0, 2);

    // Enable toggled 1-0-0-1 around the last pixel of the small raster
    guard = 0;
    while (pos[1] != frame(1) - 2 && guard < 200) begin
      step(1'b0, 1'b1);
      guard++;
    end
    check_int("dut1_reach_last_minus1", int'(pos[1]), int'(frame(1)) - 2);
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);

    // Mid-frame asynchronous reset with the default raster at col 300
    guard = 0;
    while ((pos[0] % 800) != 300 && guard < 1000) begin
      step(1'b0, 1'b1);
      guard++;
    end
    check_int("dut0_reach_col300", int'(pos[0] % 800), 300);
    repeat (3) step(1'b1, 1'b1);
    step(1'b0, 1'b1);

    // Randomised enable with occasional resets
    for (int i = 0; i < 4000; i++) begin
      step($urandom_range(0, 499) == 0, $urandom_range(0, 3) != 0);
    end
    step(1'b0, 1'b0);
    @(posedge clk);
    #2;
    for (int k = 0; k < 3; k++) check_int($sformatf("dut%0d_sb_drained", k), sb[k].size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
